// File: rtl/rng_health_monitor.sv
// Online health monitor for a raw ring-oscillator entropy bit: repetition-count
// and adaptive-proportion tests gate a STARTUP/RUN/FAIL state machine.
module rng_health_monitor #(
  parameter int RCT_CUTOFF      = 32,
  parameter int APT_WINDOW      = 512,
  parameter int APT_CUTOFF      = 410,
  parameter int STARTUP_SAMPLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  input  logic sample_en,
  input  logic fail_clear,
  output logic bit_out,
  output logic bit_valid,
  output logic health_ok,
  output logic rct_fail,
  output logic apt_fail
);

  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam int APT_W = $clog2(APT_CUTOFF + 1);
  localparam int POS_W = $clog2(APT_WINDOW + 1);
  localparam int SU_W  = $clog2(STARTUP_SAMPLES + 1);

  localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_CUTOFF);
  localparam logic [APT_W-1:0] APT_MAX  = APT_W'(APT_CUTOFF);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(APT_WINDOW - 1);
  localparam logic [SU_W-1:0]  SU_DONE  = SU_W'(STARTUP_SAMPLES);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_sync1;
  logic r_sync2;

  logic [RCT_W-1:0] r_rct_run;
  logic [RCT_W-1:0] w_rct_run_next;
  logic             r_rct_prev;

  logic [POS_W-1:0] r_apt_pos;
  logic [POS_W-1:0] w_apt_pos_next;
  logic [APT_W-1:0] r_apt_cnt;
  logic [APT_W-1:0] w_apt_cnt_next;
  logic             r_apt_ref;
  logic             w_apt_ref_next;

  logic [SU_W-1:0]  r_su_cnt;
  logic [SU_W-1:0]  w_su_cnt_next;

  logic r_rct_fail;
  logic r_apt_fail;
  logic r_bit_out;
  logic r_bit_valid;

  logic w_sample;
  logic w_take;
  logic w_clear;
  logic w_rct_hit;
  logic w_apt_hit;
  logic w_fail;
  logic w_su_done;
  logic w_emit;

  // Two-flop synchronizer: raw_in is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
  assign w_take   = sample_en && (r_state != ST_FAIL);
  assign w_clear  = fail_clear && (r_state == ST_FAIL);

  // A zero run length marks the first sample since restart.
  always_comb begin
    w_rct_run_next = r_rct_run;
    if ((r_rct_run == '0) || (w_sample != r_rct_prev)) begin
      w_rct_run_next = RCT_W'(1);
    end else if (r_rct_run != RCT_MAX) begin
      w_rct_run_next = r_rct_run + RCT_W'(1);
    end
  end

  assign w_rct_hit = w_take && (w_rct_run_next == RCT_MAX);

  always_comb begin
    w_apt_cnt_next = r_apt_cnt;
    w_apt_ref_next = r_apt_ref;
    if (r_apt_pos == '0) begin
      w_apt_ref_next = w_sample;
      w_apt_cnt_next = APT_W'(1);
    end else if ((w_sample == r_apt_ref) && (r_apt_cnt != APT_MAX)) begin
      w_apt_cnt_next = r_apt_cnt + APT_W'(1);
    end
  end

  assign w_apt_pos_next = (r_apt_pos == POS_LAST) ? '0 : r_apt_pos + POS_W'(1);
  assign w_apt_hit      = w_take && (w_apt_cnt_next == APT_MAX);

  assign w_fail        = w_rct_hit || w_apt_hit;
  assign w_su_cnt_next = r_su_cnt + SU_W'(1);
  assign w_su_done     = (r_state == ST_STARTUP) && w_take && !w_fail &&
                         (w_su_cnt_next == SU_DONE);
  assign w_emit        = (r_state == ST_RUN) && w_take && !w_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STARTUP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STARTUP: begin
        if (w_fail) begin
          w_state_next = ST_FAIL;
        end else if (w_su_done) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_fail) begin
          w_state_next = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (fail_clear) begin
          w_state_next = ST_STARTUP;
        end
      end
      default: w_state_next = ST_STARTUP;
    endcase
  end

  always_comb begin
    health_ok = 1'b0;
    if (r_state == ST_RUN) begin
      health_ok = 1'b1;
    end
  end

  // Test counters and sticky flags; fail_clear wipes them like a reset.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_rct_run  <= '0;
      r_rct_prev <= 1'b0;
      r_apt_pos  <= '0;
      r_apt_cnt  <= '0;
      r_apt_ref  <= 1'b0;
      r_su_cnt   <= '0;
      r_rct_fail <= 1'b0;
      r_apt_fail <= 1'b0;
    end else begin
      if (w_take) begin
        r_rct_run  <= w_rct_run_next;
        r_rct_prev <= w_sample;
        r_apt_pos  <= w_apt_pos_next;
        r_apt_cnt  <= w_apt_cnt_next;
        r_apt_ref  <= w_apt_ref_next;
        if (r_state == ST_STARTUP) begin
          r_su_cnt <= w_su_cnt_next;
        end
      end
      r_rct_fail <= r_rct_fail | w_rct_hit;
      r_apt_fail <= r_apt_fail | w_apt_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_bit_valid <= w_emit;
      if (w_emit) begin
        r_bit_out <= w_sample;
      end
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign rct_fail  = r_rct_fail;
  assign apt_fail  = r_apt_fail;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor with small cutoffs so every
// failure and window boundary can be reached in a few hundred cycles.
module tb_rng_health_monitor;

  logic clk = 1'b0;
  logic reset;
  logic raw_in;
  logic sample_en;
  logic fail_clear;
  logic bit_out;
  logic bit_valid;
  logic health_ok;
  logic rct_fail;
  logic apt_fail;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rng_health_monitor #(
    .RCT_CUTOFF      (4),
    .APT_WINDOW      (16),
    .APT_CUTOFF      (12),
    .STARTUP_SAMPLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (raw_in),
    .sample_en  (sample_en),
    .fail_clear (fail_clear),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .health_ok  (health_ok),
    .rct_fail   (rct_fail),
    .apt_fail   (apt_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold raw_in long enough to fill the synchronizer, then take one sample.
  task automatic feed(input logic b, input int idle);
    raw_in    = b;
    sample_en = 1'b0;
    repeat (idle) tick();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic pulse_clear();
    fail_clear = 1'b1;
    tick();
    fail_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] win2;
    logic [14:0] win3;
    win2 = 16'b0001_0001_0001_0011;
    win3 = 15'b000_1000_1000_1000;

    reset      = 1'b1;
    raw_in     = 1'b1;
    sample_en  = 1'b1;
    fail_clear = 1'b1;
    repeat (3) tick();
    check("rst bit_out",   bit_out,   0);
    check("rst bit_valid", bit_valid, 0);
    check("rst health_ok", health_ok, 0);
    check("rst rct_fail",  rct_fail,  0);
    check("rst apt_fail",  apt_fail,  0);

    // Continuous alternating stream; sample at edge t is raw from edge t-2.
    reset      = 1'b0;
    fail_clear = 1'b0;
    sample_en  = 1'b0;
    raw_in     = 1'b0;
    tick();
    raw_in = 1'b1;
    tick();
    for (int t = 0; t <= 20; t++) begin
      raw_in    = logic'(t % 2);
      sample_en = 1'b1;
      tick();
      check($sformatf("alt t%0d health_ok", t), health_ok, (t >= 7) ? 1 : 0);
      check($sformatf("alt t%0d bit_valid", t), bit_valid, (t >= 8) ? 1 : 0);
      if (t >= 8) begin
        check($sformatf("alt t%0d bit_out", t), bit_out, t % 2);
      end
    end
    sample_en = 1'b0;

    // Last streamed sample was 0: three 1s pass, the fourth trips RCT.
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, 2);
      check($sformatf("rct one%0d bit_valid", i), bit_valid, 1);
      check($sformatf("rct one%0d bit_out", i),   bit_out,   1);
    end
    feed(1'b1, 2);
    check("rct 4th bit_valid", bit_valid, 0);
    check("rct 4th rct_fail",  rct_fail,  1);
    check("rct 4th apt_fail",  apt_fail,  0);
    check("rct 4th health_ok", health_ok, 0);

    feed(1'b0, 2);
    check("fail ignore bit_valid", bit_valid, 0);
    check("fail ignore rct_fail",  rct_fail,  1);
    check("fail ignore health_ok", health_ok, 0);

    pulse_clear();
    check("clr1 rct_fail",  rct_fail,  0);
    check("clr1 health_ok", health_ok, 0);

    // Fresh window 1: 8 startup samples then 8 output samples.
    for (int i = 0; i < 16; i++) begin
      feed(logic'(i % 2), 2);
      if (i < 8) begin
        check($sformatf("su%0d health_ok", i), health_ok, (i == 7) ? 1 : 0);
        check($sformatf("su%0d bit_valid", i), bit_valid, 0);
      end else begin
        check($sformatf("w1 s%0d bit_valid", i), bit_valid, 1);
        check($sformatf("w1 s%0d bit_out", i),   bit_out,   i % 2);
      end
    end

    // Window 2: 11 matches of the first bit, must pass.
    for (int i = 15; i >= 0; i--) begin
      feed(win2[i], 2);
      check($sformatf("w2 s%0d bit_valid", 15 - i), bit_valid, 1);
      check($sformatf("w2 s%0d bit_out", 15 - i),   bit_out,   win2[i]);
      check($sformatf("w2 s%0d apt_fail", 15 - i),  apt_fail,  0);
    end

    // Window 3: 12th match trips APT on its own sample.
    for (int i = 14; i >= 0; i--) begin
      feed(win3[i], 2);
      if (i > 0) begin
        check($sformatf("w3 s%0d bit_valid", 14 - i), bit_valid, 1);
        check($sformatf("w3 s%0d apt_fail", 14 - i),  apt_fail,  0);
      end else begin
        check("w3 12th apt_fail",  apt_fail,  1);
        check("w3 12th rct_fail",  rct_fail,  0);
        check("w3 12th bit_valid", bit_valid, 0);
        check("w3 12th health_ok", health_ok, 0);
      end
    end

    pulse_clear();
    check("clr2 apt_fail",  apt_fail,  0);
    check("clr2 health_ok", health_ok, 0);

    // Idle cycles with a stuck input must not advance any counter.
    raw_in    = 1'b1;
    sample_en = 1'b0;
    repeat (20) tick();
    check("idle rct_fail",  rct_fail,  0);
    check("idle health_ok", health_ok, 0);

    for (int i = 0; i < 8; i++) begin
      feed(logic'(i % 2), 2 + int'($urandom_range(0, 3)));
      check($sformatf("gap su%0d health_ok", i), health_ok, (i == 7) ? 1 : 0);
      check($sformatf("gap su%0d rct_fail", i),  rct_fail,  0);
    end
    feed(1'b1, 2);
    check("pre-rst bit_valid", bit_valid, 1);
    check("pre-rst bit_out",   bit_out,   1);

    // Reset with a qualifying RUN sample on the same edge.
    raw_in    = 1'b0;
    sample_en = 1'b1;
    reset     = 1'b1;
    tick();
    check("midrst bit_valid", bit_valid, 0);
    check("midrst bit_out",   bit_out,   0);
    check("midrst health_ok", health_ok, 0);
    check("midrst rct_fail",  rct_fail,  0);
    check("midrst apt_fail",  apt_fail,  0);
    reset     = 1'b0;
    sample_en = 1'b0;
    tick();
    check("postrst bit_valid", bit_valid, 0);
    check("postrst health_ok", health_ok, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rng_health_monitor.md
RNG_HEALTH_MONITOR -- requirements
Module: rng_health_monitor

Interface
REQ-001 Parameter RCT_CUTOFF, default 32: run length of identical samples that declares a repetition-count failure (range 2..255).
REQ-002 Parameter APT_WINDOW, default 512: adaptive-proportion window length in samples (power of two, 16..4096).
REQ-003 Parameter APT_CUTOFF, default 410: match count within one window that declares an adaptive-proportion failure (2..APT_WINDOW).
REQ-004 Parameter STARTUP_SAMPLES, default 1024: failure-free samples required before output is enabled (1..65535).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 raw_in  input  1  asynchronous raw entropy bit (XOR of ring oscillators).
REQ-008 sample_en  input  1  take one sample this cycle when high.
REQ-009 fail_clear  input  1  single-cycle request to leave FAIL and restart.
REQ-010 bit_out  output  1  health-checked sample, forwarded to the de-bias stage.
REQ-011 bit_valid  output  1  one-cycle qualifier for bit_out.
REQ-012 health_ok  output  1  high only in RUN state.
REQ-013 rct_fail  output  1  sticky repetition-count failure flag.
REQ-014 apt_fail  output  1  sticky adaptive-proportion failure flag.

Function
REQ-015 raw_in SHALL pass through a two-flop synchronizer; the sample s is the second flop's output in the cycle sample_en is high.
REQ-016 FSM states SHALL be STARTUP, RUN and FAIL; reset enters STARTUP.
REQ-017 RCT: first sample after restart sets run=1 and prev=s; later samples set run=run+1 if s==prev, else run=1; run saturates at RCT_CUTOFF.
REQ-018 RCT failure SHALL be declared on the sample whose updated run equals RCT_CUTOFF.
REQ-019 APT: the first sample of a window sets ref=s and count=1; each later sample in the window increments count if s==ref; count saturates at APT_CUTOFF.
REQ-020 APT failure SHALL be declared on the sample whose updated count equals APT_CUTOFF; a window ends after exactly APT_WINDOW samples, and the next sample starts a new window.
REQ-021 Both tests SHALL run in STARTUP and RUN; sample_en is ignored in FAIL.
REQ-022 Failure in STARTUP or RUN SHALL move to FAIL on the next edge and set the matching sticky flag(s); simultaneous RCT and APT failure sets both flags.
REQ-023 STARTUP SHALL count samples; the STARTUP_SAMPLES-th sample without failure moves the FSM to RUN, and that sample is not output.
REQ-024 In RUN, a sample that does not fail SHALL give bit_out=s and bit_valid=1 on the next cycle; a failing sample SHALL never be output.
REQ-025 bit_valid SHALL be 0 in every cycle with no qualifying RUN sample; bit_out holds its last value when bit_valid is 0.
REQ-026 fail_clear in FAIL SHALL clear all counters and both flags and enter STARTUP; fail_clear in STARTUP or RUN has no effect.
REQ-027 Counter widths SHALL be $clog2(parameter+1); saturation prevents wrap-around.

Reset
REQ-028 While reset is high: state=STARTUP, all counters=0, synchronizer flops=0, bit_out=0, bit_valid=0, health_ok=0, rct_fail=0, apt_fail=0.
REQ-029 reset SHALL override fail_clear and sample_en in the same cycle; reset during RUN aborts any output pending for the following cycle.

Verification (parameters RCT_CUTOFF=4, APT_WINDOW=16, APT_CUTOFF=12, STARTUP_SAMPLES=8)
REQ-030 Alternating 0101... with sample_en=1 -> health_ok rises after the 8th sample; bit_valid is 1 every later cycle; bit_out repeats the input pattern 2 cycles after raw_in (synchronizer plus register).
REQ-031 In RUN, four consecutive 1 samples -> rct_fail=1, health_ok=0 next edge; the 4th 1 is never output with bit_valid=1.
REQ-032 In RUN, 12 of 16 window samples equal the window's first bit, with no run longer than 3 -> apt_fail=1 on the 12th match; a window with 11 matches passes.
REQ-033 In FAIL, pulse fail_clear -> flags clear, STARTUP re-entered; 8 clean samples later health_ok=1 again.
REQ-034 sample_en toggled randomly -> counters advance only on sample_en cycles; reset asserted mid-RUN -> all outputs 0 on the next edge.
